data_array_arbiter: RTL

DATA_ARRAY_ARBITER -- requirements
Module: data_array_arbiter

---
 rtl/data_array_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/data_array_arbiter.sv
// ---------------------------------------------------------------------------
// data_array_arbiter
//
// Purpose: arbitrates a single-ported data array between a refill write
// port (A) and a core read/write port (B). After reset the array can be
// zero-filled one word per cycle (INIT) before normal arbitration (RUN).
// Port A has priority. Port B is guaranteed a grant after STARVE_LIMIT
// consecutive losses while it is requesting.
//
// Ports:
//   clock, reset          sole clock; synchronous active-high reset
//   init_done             high once the array is initialized (RUN state)
//   a_valid/a_ready       refill write handshake (ready is a same-cycle grant)
//   a_addr/a_data/a_mask  refill byte address, write data, byte-lane mask
//   b_valid/b_ready       core request handshake (ready is a same-cycle grant)
//   b_write               1 = write, 0 = read
//   b_addr/b_data/b_mask  core byte address, write data, byte-lane mask
//   b_rvalid/b_rdata      core read response, one cycle after acceptance
//   arr_en/arr_wen        array enable / write enable
//   arr_addr              array word address (byte address [13:2])
//   arr_mask/arr_wdata    array byte-lane mask / write data
//   arr_rdata             array read data, valid the cycle after a read
// ---------------------------------------------------------------------------
module data_array_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int INIT_EN      = 1
) (
    input  logic        clock,
    input  logic        reset,
    output logic        init_done,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [13:0] a_addr,
    input  logic [31:0] a_data,
    input  logic [3:0]  a_mask,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic        b_write,
    input  logic [13:0] b_addr,
    input  logic [31:0] b_data,
    input  logic [3:0]  b_mask,
    output logic        b_rvalid,
    output logic [31:0] b_rdata,
    output logic        arr_en,
    output logic        arr_wen,
    output logic [11:0] arr_addr,
    output logic [3:0]  arr_mask,
    output logic [31:0] arr_wdata,
    input  logic [31:0] arr_rdata
);

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t        r_state;
    logic [11:0]   r_init_cnt;
    logic          r_init_done;
    logic [SW-1:0] r_starve;
    logic          r_rvalid_p1;

    logic w_init;
    logic w_run;
    logic w_b_force;
    logic w_grant_a;
    logic w_grant_b;
    logic w_unused_addr_lsbs;

    // Byte-offset bits never reach the word-addressed array.
    assign w_unused_addr_lsbs = ^{a_addr[1:0], b_addr[1:0]};

    // Saturating increment of the starvation counter.
    function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
        return (v == LIMIT) ? v : v + SW'(1);
    endfunction

    // Everything the block drives is forced low while reset is sampled high,
    // so outputs are clean in the reset cycle itself, not just after it.
    assign w_init    = (r_state == ST_INIT) && !reset;
    assign w_run     = (r_state == ST_RUN) && !reset;
    assign w_b_force = (r_starve == LIMIT);
    assign w_grant_a = w_run && a_valid && (!b_valid || !w_b_force);
    assign w_grant_b = w_run && b_valid && (!a_valid || w_b_force);

    // ---- stage p0: grant and array drive (combinational) ----
    always_comb begin
        arr_en    = 1'b0;
        arr_wen   = 1'b0;
        arr_addr  = 12'h000;
        arr_mask  = 4'h0;
        arr_wdata = 32'h0000_0000;
        if (w_init) begin
            arr_en    = 1'b1;
            arr_wen   = 1'b1;
            arr_addr  = r_init_cnt;
            arr_mask  = 4'hF;
        end else if (w_grant_a) begin
            arr_en    = 1'b1;
            arr_wen   = 1'b1;
            arr_addr  = a_addr[13:2];
            arr_mask  = a_mask;
            arr_wdata = a_data;
        end else if (w_grant_b) begin
            arr_en    = 1'b1;
            arr_wen   = b_write;
            arr_addr  = b_addr[13:2];
            arr_mask  = b_mask;
            arr_wdata = b_data;
        end
    end

    assign a_ready   = w_grant_a;
    assign b_ready   = w_grant_b;
    assign init_done = r_init_done && !reset;

    // ---- stage p1: read response, aligned with arr_rdata ----
    assign b_rvalid = r_rvalid_p1 && !reset;
    assign b_rdata  = b_rvalid ? arr_rdata : 32'h0000_0000;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
            r_init_cnt  <= 12'h000;
            r_init_done <= (INIT_EN == 0);
            r_starve    <= '0;
            r_rvalid_p1 <= 1'b0;
        end else begin
            r_rvalid_p1 <= w_grant_b && !b_write;

            case (r_state)
                ST_INIT: begin
                    r_init_cnt <= r_init_cnt + 12'h001;
                    if (r_init_cnt == 12'hFFF) begin
                        r_state     <= ST_RUN;
                        r_init_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase

            // Counts consecutive cycles in which B requested and lost to A.
            if (!b_valid || w_grant_b) begin
                r_starve <= '0;
            end else if (w_grant_a) begin
                r_starve <= sat_inc(r_starve);
            end
        end
    end

endmodule
